// File: rtl/lix_pkg.sv
// Shared definitions for the lix output-stage datapath.
// The state encoding doubles as the occupancy count.
package lix_pkg;

  localparam int LIX_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lix_state_e;

endpackage

// File: rtl/lix_dreg.sv
// W-bit data register with load enable and asynchronous active-high clear.
module lix_dreg
  import lix_pkg::*;
#(
  parameter int W = LIX_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/lix_skid_reg.sv
// Two-entry skid output stage: accepts words from an upstream register stage
// and presents them downstream on a valid/ready handshake with a registered ready.
module lix_skid_reg
  import lix_pkg::*;
#(
  parameter int W            = LIX_W_DEFAULT,
  parameter bit ZERO_INVALID = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_vld,
  output logic         o_rdy,
  input  logic [W-1:0] i_x,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_z,
  output logic [1:0]   o_cnt
);

  lix_state_e   state;
  lix_state_e   state_nxt;
  logic         push;
  logic         pop;
  logic         main_ld;
  logic         main_from_skid;
  logic         skid_ld;
  logic [W-1:0] main_d;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready depends only on registered state, so i_rdy never reaches o_rdy.
  assign o_rdy = (state != FULL) && !rst_i;
  assign o_vld = (state != EMPTY);
  assign o_cnt = state;
  assign push  = i_vld && o_rdy;
  assign pop   = o_vld && i_rdy;

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          main_ld   = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_ld = 1'b1;
        end else if (push) begin
          skid_ld   = 1'b1;
          state_nxt = FULL;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign main_d = main_from_skid ? skid_q : i_x;

  lix_dreg #(.W(W)) u_main (
    .clk (clk_i),
    .rst (rst_i),
    .ld  (main_ld),
    .d   (main_d),
    .q   (main_q)
  );

  lix_dreg #(.W(W)) u_skid (
    .clk (clk_i),
    .rst (rst_i),
    .ld  (skid_ld),
    .d   (i_x),
    .q   (skid_q)
  );

  generate
    if (ZERO_INVALID) begin : g_zero
      assign o_z = main_q & {W{o_vld}};
    end else begin : g_hold
      assign o_z = main_q;
    end
  endgenerate

endmodule

// File: tb/tb_lix_skid_reg.sv
// Directed bench for lix_skid_reg: reset, streaming, backpressure, drain,
// push-with-pop and both output-zeroing variants.
module tb_lix_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vld;
  logic        i_rdy;
  logic [31:0] i_x;

  logic        rdy_a, vld_a;
  logic [31:0] z_a;
  logic [1:0]  cnt_a;
  logic        rdy_b, vld_b;
  logic [31:0] z_b;
  logic [1:0]  cnt_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lix_skid_reg #(.W(32), .ZERO_INVALID(1'b0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .i_vld (i_vld),
    .o_rdy (rdy_a),
    .i_x   (i_x),
    .o_vld (vld_a),
    .i_rdy (i_rdy),
    .o_z   (z_a),
    .o_cnt (cnt_a)
  );

  lix_skid_reg #(.W(32), .ZERO_INVALID(1'b1)) dut_z (
    .clk_i (clk),
    .rst_i (rst),
    .i_vld (i_vld),
    .o_rdy (rdy_b),
    .i_x   (i_x),
    .o_vld (vld_b),
    .i_rdy (i_rdy),
    .o_z   (z_b),
    .o_cnt (cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] x);
    i_vld = 1'b1;
    i_x   = x;
  endtask

  task automatic idle();
    i_vld = 1'b0;
    i_x   = 'x;
  endtask

  initial begin
    rst   = 1'b1;
    i_rdy = 1'b0;
    idle();
    cyc();
    cyc();
    check("rst_vld", {31'd0, vld_a}, 32'd0);
    check("rst_cnt", {30'd0, cnt_a}, 32'd0);
    check("rst_z", z_a, 32'd0);
    check("rst_z_zi", z_b, 32'd0);
    check("rst_rdy", {31'd0, rdy_a}, 32'd0);
    rst = 1'b0;
    cyc();
    check("rel_rdy", {31'd0, rdy_a}, 32'd1);

    // Fill to FULL, then reset between edges.
    push(32'h1111_1111);
    cyc();
    check("fill1_cnt", {30'd0, cnt_a}, 32'd1);
    check("fill1_z", z_a, 32'h1111_1111);
    push(32'h2222_2222);
    cyc();
    check("fill2_cnt", {30'd0, cnt_a}, 32'd2);
    check("fill2_rdy", {31'd0, rdy_a}, 32'd0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_vld", {31'd0, vld_a}, 32'd0);
    check("mid_rst_cnt", {30'd0, cnt_a}, 32'd0);
    check("mid_rst_z", z_a, 32'd0);
    check("mid_rst_rdy", {31'd0, rdy_a}, 32'd0);
    check("mid_rst_skid", dut.u_skid.q, 32'd0);
    cyc();
    check("mid_rst_rdy_hold", {31'd0, rdy_a}, 32'd0);
    rst = 1'b0;
    cyc();
    check("mid_rel_rdy", {31'd0, rdy_a}, 32'd1);
    check("mid_rel_cnt", {30'd0, cnt_a}, 32'd0);

    // Streaming at one word per cycle.
    i_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      push(32'(k));
      cyc();
      check("stream_z", z_a, 32'(k));
      check("stream_cnt", {30'd0, cnt_a}, 32'd1);
      check("stream_rdy", {31'd0, rdy_a}, 32'd1);
    end
    idle();
    cyc();
    check("stream_end_cnt", {30'd0, cnt_a}, 32'd0);
    check("stream_end_vld", {31'd0, vld_a}, 32'd0);

    // Backpressure.
    i_rdy = 1'b0;
    push(32'hAAAA_0000);
    cyc();
    check("bp1_cnt", {30'd0, cnt_a}, 32'd1);
    push(32'hBBBB_0000);
    cyc();
    check("bp2_cnt", {30'd0, cnt_a}, 32'd2);
    check("bp2_rdy", {31'd0, rdy_a}, 32'd0);
    check("bp2_z", z_a, 32'hAAAA_0000);
    push(32'hCCCC_0000);
    cyc();
    check("bp3_cnt", {30'd0, cnt_a}, 32'd2);
    check("bp3_z", z_a, 32'hAAAA_0000);
    check("bp3_vld", {31'd0, vld_a}, 32'd1);
    idle();

    // Drain.
    i_rdy = 1'b1;
    cyc();
    check("dr1_z", z_a, 32'hBBBB_0000);
    check("dr1_cnt", {30'd0, cnt_a}, 32'd1);
    check("dr1_rdy", {31'd0, rdy_a}, 32'd1);
    cyc();
    check("dr2_cnt", {30'd0, cnt_a}, 32'd0);
    check("dr2_vld", {31'd0, vld_a}, 32'd0);
    cyc();
    check("dr3_cnt", {30'd0, cnt_a}, 32'd0);
    check("dr3_z_hold", z_a, 32'hBBBB_0000);

    // Simultaneous push and pop in ONE.
    push(32'h5);
    cyc();
    check("pp1_z", z_a, 32'h5);
    push(32'h6);
    cyc();
    check("pp2_z", z_a, 32'h6);
    check("pp2_cnt", {30'd0, cnt_a}, 32'd1);
    check("pp2_skid", dut.u_skid.q, 32'hBBBB_0000);
    idle();
    cyc();
    check("pp3_cnt", {30'd0, cnt_a}, 32'd0);

    // Output zeroing on invalid.
    push(32'hDEAD_BEEF);
    cyc();
    check("zi1_z", z_b, 32'hDEAD_BEEF);
    check("zi1_vld", {31'd0, vld_b}, 32'd1);
    check("hz1_z", z_a, 32'hDEAD_BEEF);
    idle();
    cyc();
    check("zi2_z", z_b, 32'd0);
    check("zi2_vld", {31'd0, vld_b}, 32'd0);
    check("hz2_z", z_a, 32'hDEAD_BEEF);
    cyc();
    check("zi3_z", z_b, 32'd0);
    check("hz3_z", z_a, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lix_skid_reg.md
Name: lix_skid_reg

Overview:
Consumer-side output stage for the lix register datapath. It accepts words from an upstream enable/valid register stage and presents them downstream with a valid/ready handshake. A 2-entry skid buffer absorbs downstream backpressure without combinational ready paths. Its registered ready output drives the upstream stage's load enable.

Parameters:
W, 32, data width in bits
ZERO_INVALID, 0, if 1 then o_z is forced to all-zero whenever o_vld=0; if 0 then o_z holds the last presented word

Ports:
clk_i  input  1  single clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
i_vld  input  1  upstream word valid
o_rdy  output  1  upstream ready; a transfer occurs on i_vld && o_rdy at a rising clk_i
i_x  input  W  upstream data
o_vld  output  1  downstream word valid
i_rdy  input  1  downstream ready; a pop occurs on o_vld && i_rdy at a rising clk_i
o_z  output  W  downstream data
o_cnt  output  2  occupancy: 0, 1 or 2

Behaviour:
- Storage: main register (drives o_z) and skid register. Each data register is written only when it captures an accepted word.
- State machine:
  - EMPTY (cnt=0)
  - ONE (cnt=1, main valid)
  - FULL (cnt=2, main and skid valid)
- Registered outputs: o_vld = (state!=EMPTY); o_rdy = (state!=FULL) && !rst_i. There is no combinational path from i_rdy to o_rdy.
- EMPTY:
  - push -> main<=i_x, go to ONE.
  - no push -> stay.
  - i_rdy is ignored.
- ONE:
  - push & pop -> main<=i_x, stay ONE (full throughput).
  - push & !pop -> skid<=i_x, go to FULL.
  - !push & pop -> go to EMPTY.
  - neither -> hold.
- FULL:
  - pop -> main<=skid, go to ONE.
  - no pop -> hold.
  - i_vld is ignored because o_rdy=0.
- Latency: a word accepted at edge N is visible on o_z/o_vld after edge N.
- Throughput: 1 word/cycle when i_rdy is held high.
- Order: strict FIFO. The skid word is always presented after the current main word.
- Stability: while o_vld && !i_rdy, o_z and o_vld do not change.
- Reset (asynchronous assert, synchronous-safe deassert handled externally):
  - state=EMPTY, main=0, skid=0, o_vld=0, o_cnt=0, o_z=0.
  - o_rdy=0 while rst_i is high, and 1 on the first cycle after release.
  - Reset asserted mid-transfer discards all held words immediately. No partial update occurs.
- ZERO_INVALID=1: o_z = o_vld ? main : 0 (one AND level). With ZERO_INVALID=0, o_z = main.
- X handling: i_x is sampled only on push, so X on i_x while i_vld=0 must not propagate.

Decomposition:
- Shared package lix_pkg:
  - state encoding localparams: EMPTY=2'd0, ONE=2'd1, FULL=2'd2 (o_cnt equals the state encoding).
  - LIX_W_DEFAULT=32.
- One natural sub-module: lix_dreg, a W-bit register with load enable and asynchronous active-high clear. It is instantiated twice (main, skid). Control next-state logic stays in lix_skid_reg.

Test Plan:
- Reset mid-stream:
  - Stimulus: fill to FULL with 0x11111111 and 0x22222222, then pulse rst_i asynchronously between edges.
  - Response: o_vld=0, o_cnt=0, o_z=0 immediately; o_rdy=0 during reset and 1 one cycle after release.
- Streaming:
  - Stimulus: i_rdy=1, push 0x00000001..0x00000008 on consecutive cycles.
  - Response: o_z yields the same sequence one cycle later; o_cnt stays 1; o_rdy stays 1 throughout.
- Backpressure:
  - Stimulus: i_rdy=0, push 0xAAAA0000 then 0xBBBB0000.
  - Response: o_cnt=2, o_rdy=0; a third push of 0xCCCC0000 is ignored; o_z holds 0xAAAA0000.
- Drain:
  - Stimulus: from the backpressure end state, i_rdy=1 for 3 cycles.
  - Response: o_z shows 0xAAAA0000 then 0xBBBB0000, then o_vld=0; o_cnt goes 2,1,0; 0xCCCC0000 never appears.
- Simultaneous push and pop in ONE:
  - Stimulus: main=0x5, push 0x6 with i_rdy=1.
  - Response: o_z=0x6, o_cnt=1, the skid register is not written.
- ZERO_INVALID:
  - Stimulus: ZERO_INVALID=1, push 0xDEADBEEF, pop, then idle.
  - Response: o_z=0xDEADBEEF for one cycle, then 0.
  - Same stimulus with ZERO_INVALID=0: o_z holds 0xDEADBEEF after o_vld drops.
